// File: rtl/sprite_rom_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sprite_rom_arbiter_pkg
//   Shared constants and types for the sprite ROM path: the geometry of one
//   sprite frame, the animation-type encoding, and the helper that builds a
//   frame-bank select from an animation type and a frame index.
//   No ports (package).
//   Build option: SPRITE_ARB_FIXED_PRIO_EN (see sprite_rom_arbiter.sv).
// ----------------------------------------------------------------------------
package sprite_rom_arbiter_pkg;

    localparam int unsigned SPRITE_W     = 32;
    localparam int unsigned SPRITE_H     = 48;
    localparam int unsigned SPRITE_WORDS = SPRITE_W * SPRITE_H;   // 1536

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        JUMP = 2'd2,
        FALL = 2'd3
    } anim_t;

    // Bank select = {animation type, frame LSB}; only two frames per type.
    function automatic logic [2:0] bank_enc(input anim_t anim, input logic frame_lsb);
        return {anim, frame_lsb};
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// ----------------------------------------------------------------------------
// sprite_rom_arbiter_if
//   Bundles the requester handshake, the ROM port and the response path of
//   the sprite ROM arbiter.
//   Signals:
//     flush      frame-start / revive pulse, drops in-flight reads
//     req_valid  per-requester read request (NUM_REQ)
//     req_bank   frame bank, slice i for requester i (NUM_REQ*BANK_W)
//     req_addr   pixel address, slice i for requester i (NUM_REQ*ADDR_W)
//     req_ready  one-hot grant (NUM_REQ)
//     rom_addr   registered {bank, addr} to the ROM (BANK_W+ADDR_W)
//     rom_en     registered ROM read enable
//     rom_data   ROM read data (DATA_W)
//     rsp_valid  one-hot owner of rsp_data (NUM_REQ)
//     rsp_data   routed read data (DATA_W)
//   Modports: slave = arbiter, master = requesters + ROM environment.
//   Build option: SPRITE_ARB_FIXED_PRIO_EN has no effect on this interface.
// ----------------------------------------------------------------------------
interface sprite_rom_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned BANK_W  = 3,
    parameter int unsigned DATA_W  = 8
);
    import sprite_rom_arbiter_pkg::*;

    logic                       flush;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*BANK_W-1:0]  req_bank;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ-1:0]         req_ready;
    logic [BANK_W+ADDR_W-1:0]   rom_addr;
    logic                       rom_en;
    logic [DATA_W-1:0]          rom_data;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [DATA_W-1:0]          rsp_data;

    modport slave (
        input  flush, req_valid, req_bank, req_addr, rom_data,
        output req_ready, rom_addr, rom_en, rsp_valid, rsp_data
    );

    modport master (
        output flush, req_valid, req_bank, req_addr, rom_data,
        input  req_ready, rom_addr, rom_en, rsp_valid, rsp_data
    );

endinterface

// File: rtl/sprite_rom_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// sprite_rom_arbiter_rr_picker
//   Picks one requester per cycle.
//   Default build: round-robin, search starts at i_ptr and wraps mod NUM_REQ.
//   SPRITE_ARB_FIXED_PRIO_EN: plain priority encoder, lowest index wins;
//   the pointer input does not exist in that build.
//   Ports:
//     i_req    request vector (NUM_REQ)
//     i_ptr    round-robin start index (default build only)
//     o_grant  one-hot grant, 0 when no request
//     o_idx    index of the granted requester
//     o_any    a grant was issued
// ----------------------------------------------------------------------------
module sprite_rom_arbiter_rr_picker #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
`ifndef SPRITE_ARB_FIXED_PRIO_EN
    input  logic [PTR_W-1:0]   i_ptr,
`endif
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

`ifdef SPRITE_ARB_FIXED_PRIO_EN

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!o_any && i_req[k]) begin
                o_any      = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = PTR_W'(k);
            end
        end
    end

`else

    int unsigned w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Candidate index (ptr + k) mod NUM_REQ; ptr < NUM_REQ always.
            w_j = 32'(i_ptr) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = PTR_W'(w_j);
            end
        end
    end

`endif

endmodule

// File: rtl/sprite_rom_arbiter.sv
// ----------------------------------------------------------------------------
// sprite_rom_arbiter
//   Shares one synchronous sprite ROM read port between NUM_REQ sprite
//   controllers. One request is granted per clock; the ROM address is
//   registered, and a tag pipe of depth ROM_LAT+1 routes the returning data
//   to the granted requester with a one-hot valid pulse. Total latency from
//   grant to response is ROM_LAT+1 cycles, fully pipelined.
//   Ports:
//     Clk      clock
//     Reset_n  asynchronous active-low reset
//     bus      sprite_rom_arbiter_if.slave (requests, ROM port, responses)
//   Build option: define SPRITE_ARB_FIXED_PRIO_EN for fixed priority
//   (lowest index first, no round-robin pointer); otherwise round-robin.
// ----------------------------------------------------------------------------
module sprite_rom_arbiter
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned BANK_W  = 3,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    sprite_rom_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned RA_W  = BANK_W + ADDR_W;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_gidx;
    logic               w_any;
    logic [RA_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]  w_rsp_data;

    logic [RA_W-1:0]    r_rom_addr;
    logic               r_rom_en;
    // Each stage holds the one-hot owner id; a non-zero id is the valid bit.
    logic [ROM_LAT:0][NUM_REQ-1:0] r_tag;

    // No grant is offered during reset or on a flush cycle.
    always_comb begin
        w_req = bus.req_valid;
        if (!Reset_n || bus.flush) begin
            w_req = '0;
        end
    end

`ifdef SPRITE_ARB_FIXED_PRIO_EN

    sprite_rom_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req   (w_req),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

`else

    logic [PTR_W-1:0] r_rr_ptr;

    sprite_rom_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= (32'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + PTR_W'(1);
        end
    end

`endif

    // Grant is one-hot, so OR-ing the masked slices selects the winner.
    always_comb begin
        w_sel_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_sel_addr |
                             {bus.req_bank[i*BANK_W +: BANK_W],
                              bus.req_addr[i*ADDR_W +: ADDR_W]};
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr <= '0;
            r_rom_en   <= 1'b0;
        end else begin
            r_rom_en <= w_any;
            if (w_any) begin
                r_rom_addr <= w_sel_addr;
            end
        end
    end

    // Stage 0 lines up with rom_addr/rom_en; stage ROM_LAT with rom_data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tag <= '0;
        end else if (bus.flush) begin
            r_tag <= '0;
        end else begin
            r_tag[0] <= w_grant;
            for (int unsigned k = 1; k <= ROM_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    always_comb begin
        w_rsp_data = '0;
        if (|r_tag[ROM_LAT]) begin
            w_rsp_data = bus.rom_data;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rom_addr  = r_rom_addr;
    assign bus.rom_en    = r_rom_en;
    assign bus.rsp_valid = r_tag[ROM_LAT];
    assign bus.rsp_data  = w_rsp_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;
    import sprite_rom_arbiter_pkg::*;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned BANK_W  = 3;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ROM_LAT = 1;

    logic Clk;
    logic Reset_n;

    sprite_rom_arbiter_if #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .BANK_W  (BANK_W),
        .DATA_W  (DATA_W)
    ) bus ();

    sprite_rom_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .BANK_W  (BANK_W),
        .DATA_W  (DATA_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // ROM contents model
    function automatic logic [7:0] rom_fn(input logic [13:0] a);
        return a[7:0] ^ {a[13:11], a[12:8]} ^ 8'h5A;
    endfunction

    logic [7:0] rom_pipe [ROM_LAT];
    always @(posedge Clk) begin
        rom_pipe[0] <= rom_fn(bus.rom_addr);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_data = rom_pipe[ROM_LAT-1];

    // Requester-side stimulus state
    logic [2:0]  bank [2];
    logic [10:0] addr [2];
    int unsigned ptr_m = 0;

    task automatic drive_bus();
        bus.req_bank = {bank[1], bank[0]};
        bus.req_addr = {addr[1], addr[0]};
    endtask

    task automatic next();
        @(posedge Clk);
        #1;
    endtask

    // Expected grant for two requesters
    function automatic logic [1:0] model_grant(input logic [1:0] v, input logic fl,
                                               input int unsigned p);
        if (fl || v == 2'b00) return 2'b00;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        return v[0] ? 2'b01 : 2'b10;
`else
        if (v == 2'b11) return (p == 0) ? 2'b01 : 2'b10;
        return v;
`endif
    endfunction

    function automatic int unsigned next_ptr(input logic [1:0] g, input int unsigned p);
        if (g == 2'b01) return 1;
        if (g == 2'b10) return 0;
        return p;
    endfunction

    // Scoreboard
    typedef struct {
        logic [1:0]  id;
        logic [7:0]  data;
        int unsigned due;
    } exp_t;
    exp_t sb[$];

    always @(negedge Clk) begin
        exp_t e;
        if (!Reset_n) begin
            sb.delete();
            checks++;
            if (bus.rsp_valid !== 2'b00) begin
                failures++;
                $display("FAIL rsp_in_reset got=%b exp=00", bus.rsp_valid);
            end
        end else begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL rsp_missing id=%b due=%0d now=%0d", sb[0].id, sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (bus.rsp_valid !== e.id || bus.rsp_data !== e.data) begin
                    failures++;
                    $display("FAIL rsp got=%b/%h exp=%b/%h cyc=%0d",
                             bus.rsp_valid, bus.rsp_data, e.id, e.data, cyc);
                end
            end else if (bus.rsp_valid !== 2'b00) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected got=%b exp=00 cyc=%0d", bus.rsp_valid, cyc);
            end
            if (bus.flush) sb.delete();
            if ((bus.req_valid & bus.req_ready) != 2'b00) begin
                e.id   = bus.req_ready;
                e.data = bus.req_ready[1] ? rom_fn({bank[1], addr[1]}) : rom_fn({bank[0], addr[0]});
                e.due  = cyc + ROM_LAT + 1;
                sb.push_back(e);
            end
        end
    end

    task automatic test_reset();
        Reset_n = 1'b0;
        bus.flush = 1'b0;
        bus.req_valid = 2'b11;
        bank[0] = 3'd0; addr[0] = 11'd0;
        bank[1] = 3'd1; addr[1] = 11'd1;
        drive_bus();
        repeat (3) next();
        @(negedge Clk);
        checks++;
        if (bus.req_ready !== 2'b00 || bus.rom_en !== 1'b0 || bus.rsp_valid !== 2'b00 ||
            bus.rom_addr !== 14'h0 || bus.rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%b/%b/%h/%h exp=00/0/00/0000/00",
                     bus.req_ready, bus.rom_en, bus.rsp_valid, bus.rom_addr, bus.rsp_data);
        end
        next();
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++;
            $display("FAIL reset_first_grant got=%b exp=01", bus.req_ready);
        end
        bus.req_valid = 2'b00;
        ptr_m = 0;
        next();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp;
        logic [13:0] prev_a;
        bit          prev_v;
        int          g;
        prev_v = 0;
        prev_a = '0;
        bank[0] = 3'd1; bank[1] = 3'd6;
        addr[0] = 11'($urandom); addr[1] = 11'($urandom);
        for (int i = 0; i < 6; i++) begin
            bus.req_valid = 2'b11;
            drive_bus();
            @(negedge Clk);
            exp = model_grant(2'b11, 1'b0, ptr_m);
            checks++;
            if (bus.req_ready !== exp) begin
                failures++;
                $display("FAIL rr_grant[%0d] got=%b exp=%b", i, bus.req_ready, exp);
            end
            if (prev_v) begin
                checks++;
                if (bus.rom_en !== 1'b1 || bus.rom_addr !== prev_a) begin
                    failures++;
                    $display("FAIL rr_rom_addr[%0d] got=%b/%h exp=1/%h", i, bus.rom_en, bus.rom_addr, prev_a);
                end
            end
            g = exp[1] ? 1 : 0;
            prev_a = {bank[g], addr[g]};
            prev_v = 1;
            ptr_m = next_ptr(exp, ptr_m);
            next();
            addr[g] = 11'($urandom);
        end
        bus.req_valid = 2'b00;
        drive_bus();
        @(negedge Clk);
        checks++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== prev_a || bus.req_ready !== 2'b00) begin
            failures++;
            $display("FAIL rr_last_addr got=%b/%h/%b exp=1/%h/00", bus.rom_en, bus.rom_addr, bus.req_ready, prev_a);
        end
        repeat (3) next();
    endtask

    task automatic test_single();
        logic [13:0] exp_a;
        bank[1] = bank_enc(JUMP, 1'b1);
        addr[1] = 11'd100;
        exp_a = {bank[1], addr[1]};
        bus.req_valid = 2'b10;
        drive_bus();
        @(negedge Clk);
        checks++;
        if (bus.req_ready !== 2'b10) begin
            failures++;
            $display("FAIL single_grant got=%b exp=10", bus.req_ready);
        end
        ptr_m = next_ptr(2'b10, ptr_m);
        next();
        bus.req_valid = 2'b00;
        @(negedge Clk);
        checks++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== exp_a) begin
            failures++;
            $display("FAIL single_rom_addr got=%b/%h exp=1/%h", bus.rom_en, bus.rom_addr, exp_a);
        end
        next();
        @(negedge Clk);
        checks++;
        if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== rom_fn(exp_a)) begin
            failures++;
            $display("FAIL single_rsp got=%b/%h exp=10/%h", bus.rsp_valid, bus.rsp_data, rom_fn(exp_a));
        end
        checks++;
        if (bus.rom_en !== 1'b0 || bus.rom_addr !== exp_a) begin
            failures++;
            $display("FAIL idle_hold got=%b/%h exp=0/%h", bus.rom_en, bus.rom_addr, exp_a);
        end
        next();
    endtask

    task automatic test_flush();
        logic [1:0] exp;
        bus.req_valid = 2'b01;
        drive_bus();
        @(negedge Clk);
        exp = model_grant(2'b01, 1'b0, ptr_m);
        checks++;
        if (bus.req_ready !== exp) begin
            failures++;
            $display("FAIL flush_pre_grant got=%b exp=%b", bus.req_ready, exp);
        end
        ptr_m = next_ptr(exp, ptr_m);
        next();
        bus.req_valid = 2'b11;
        bus.flush = 1'b1;
        @(negedge Clk);
        checks++;
        if (bus.req_ready !== 2'b00) begin
            failures++;
            $display("FAIL flush_blocks_grant got=%b exp=00", bus.req_ready);
        end
        next();
        bus.flush = 1'b0;
        @(negedge Clk);
        checks++;
        if (bus.rsp_valid !== 2'b00 || bus.rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL flush_suppress got=%b/%h exp=00/00", bus.rsp_valid, bus.rsp_data);
        end
        exp = model_grant(2'b11, 1'b0, ptr_m);
        checks++;
        if (bus.req_ready !== exp) begin
            failures++;
            $display("FAIL flush_post_grant got=%b exp=%b", bus.req_ready, exp);
        end
        ptr_m = next_ptr(exp, ptr_m);
        next();
        bus.req_valid = 2'b00;
        repeat (3) next();
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 2'b01;
        drive_bus();
        @(negedge Clk);
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_grant got=%b exp=01", bus.req_ready);
        end
        next();
        bus.req_valid = 2'b00;
        Reset_n = 1'b0;
        @(negedge Clk);
        checks++;
        if (bus.rom_en !== 1'b0 || bus.rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_clear got=%b/%b exp=0/00", bus.rom_en, bus.rsp_valid);
        end
        next();
        Reset_n = 1'b1;
        ptr_m = 0;
        bus.req_valid = 2'b11;
        @(negedge Clk);
        checks++;
        if (bus.rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_no_rsp got=%b exp=00", bus.rsp_valid);
        end
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_ptr got=%b exp=01", bus.req_ready);
        end
        ptr_m = next_ptr(2'b01, ptr_m);
        next();
        bus.req_valid = 2'b00;
        repeat (3) next();
    endtask

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            checks++;
            if (bus.req_ready !== 2'b01) begin
                failures++;
                $display("FAIL fixed_grant[%0d] got=%b exp=01", i, bus.req_ready);
            end
            next();
        end
        bus.req_valid = 2'b00;
        repeat (3) next();
    endtask
`endif

    task automatic test_back_to_back();
        logic [1:0]  pend, v, exp, prev_exp;
        logic [13:0] prev_a;
        logic        fl;
        pend = 2'b00;
        prev_exp = 2'b00;
        prev_a = '0;
        for (int i = 0; i < 40; i++) begin
            v = pend | 2'($urandom_range(0, 3));
            for (int r = 0; r < 2; r++) begin
                if (v[r] && !pend[r]) begin
                    bank[r] = 3'($urandom);
                    addr[r] = 11'($urandom);
                end
            end
            fl = ($urandom_range(0, 7) == 0);
            bus.req_valid = v;
            bus.flush = fl;
            drive_bus();
            @(negedge Clk);
            exp = model_grant(v, fl, ptr_m);
            checks++;
            if (bus.req_ready !== exp) begin
                failures++;
                $display("FAIL b2b_grant[%0d] got=%b exp=%b v=%b fl=%b", i, bus.req_ready, exp, v, fl);
            end
            if (prev_exp != 2'b00) begin
                checks++;
                if (bus.rom_en !== 1'b1 || bus.rom_addr !== prev_a) begin
                    failures++;
                    $display("FAIL b2b_rom[%0d] got=%b/%h exp=1/%h", i, bus.rom_en, bus.rom_addr, prev_a);
                end
            end else begin
                checks++;
                if (bus.rom_en !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_rom_idle[%0d] got=%b exp=0", i, bus.rom_en);
                end
            end
            if (exp != 2'b00) prev_a = exp[1] ? {bank[1], addr[1]} : {bank[0], addr[0]};
            prev_exp = exp;
            ptr_m = next_ptr(exp, ptr_m);
            pend = v & ~exp;
            next();
        end
        bus.req_valid = 2'b00;
        bus.flush = 1'b0;
        repeat (4) next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_flush();
        test_reset_mid();
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_back_to_back();
        @(negedge Clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
